serial_addsub_seq: RTL and testbench

// - Bit-serial signed add/subtract sequencer built around one shared fa full-adder cell.
// - Latches two WIDTH-bit two's-complement operands and feeds them LSB-first through the fa,
//   one bit per clock, with a registered carry.
// - Returns the WIDTH-bit result and an overflow flag.
// - Area-cheap alternative to the parallel ripple adder in the sign add/sub datapath.

---
 rtl/serial_addsub_seq.sv | 115 +++++++++++
 tb/tb_serial_addsub_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_seq.sv
// rtl/serial_addsub_seq.sv - bit-serial signed add/subtract sequencer around one shared fa cell
// Optional saturation of overflowed results: define SERIAL_ADDSUB_SAT_EN.

module fa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sout,
   output logic cout
);
   assign sout = a ^ b ^ c;
   assign cout = (a & b) | (c & (a ^ b));
endmodule

module serial_addsub_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sign_a;
   logic             sign_b;
   logic             fa_sout;
   logic             fa_cout;
   logic             ovf_next;
   logic [WIDTH-1:0] shifted;

   fa u_fa (
      .a    (sa[0]),
      .b    (sb[0]),
      .c    (carry),
      .sout (fa_sout),
      .cout (fa_cout)
   );

   assign busy     = (state == RUN);
   assign done     = (state == DONE);
   assign ovf_next = (sign_a == sign_b) && (fa_sout != sign_a);
   assign shifted  = {fa_sout, result[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sa       <= '0;
         sb       <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  // subtraction is a + ~b + 1, the +1 entering as the initial carry
                  state    <= RUN;
                  sa       <= a;
                  sb       <= b ^ {WIDTH{op_sub}};
                  carry    <= op_sub;
                  cnt      <= '0;
                  sign_a   <= a[WIDTH-1];
                  sign_b   <= b[WIDTH-1] ^ op_sub;
                  result   <= '0;
                  overflow <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               carry <= fa_cout;
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state    <= DONE;
                  overflow <= ovf_next;
`ifdef SERIAL_ADDSUB_SAT_EN
                  // clamp so the DONE cycle already presents the saturated value
                  if (ovf_next)
                     result <= sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                  else
                     result <= shifted;
`else
                  result   <= shifted;
`endif
               end else begin
                  result <= shifted;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_addsub_seq.sv
// tb/tb_serial_addsub_seq.sv - directed self-checking bench for serial_addsub_seq
// Inputs driven and outputs sampled on the falling edge.

module tb_serial_addsub_seq;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         overflow;

   int total = 0;
   int bad   = 0;

   serial_addsub_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
      a      = ta;
      b      = tb_v;
      op_sub = ts;
      start  = 1'b1;
   endtask

   // cycle 0 is the one with start high; returns cycle index of done and busy count
   task automatic follow(input int inj, output int dcyc, output int bcnt);
      dcyc = 0;
      bcnt = 0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 40; c++) begin
         if (c == inj)
            issue(8'h7F, 8'h7F, 1'b0);
         else
            start = 1'b0;
         if (done) begin
            dcyc = c;
            break;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_seen", (dcyc != 0), 1);
   endtask

   task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                     input logic ts, input logic [W-1:0] exp_res, input logic exp_ovf);
      int dc;
      int bc;
      @(negedge clk);
      issue(ta, tb_v, ts);
      follow(0, dc, bc);
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_ovf"}, overflow, exp_ovf);
      chk({tag, "_lat"}, dc, W + 1);
      chk({tag, "_busycnt"}, bc, W);
      chk({tag, "_busy_in_done"}, busy, 0);
   endtask

   initial begin
      int dc;
      int bc;
      int dones;
      rst    = 1'b1;
      start  = 1'b0;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_ovf", overflow, 0);
      rst = 1'b0;

      op("add_5_3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
      op("sub_3_5", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0);
      op("add_F0_F0", 8'hF0, 8'hF0, 1'b0, 8'hE0, 1'b0);
      op("sub_80_80", 8'h80, 8'h80, 1'b1, 8'h00, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
      op("add_7F_01", 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b1);
      op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h80, 1'b1);
      op("add_80_FF", 8'h80, 8'hFF, 1'b0, 8'h80, 1'b1);
      op("sub_7F_FF", 8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1);
      op("add_40_40", 8'h40, 8'h40, 1'b0, 8'h7F, 1'b1);
`else
      op("add_7F_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);
      op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
      op("add_80_FF", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1);
      op("sub_7F_FF", 8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1);
      op("add_40_40", 8'h40, 8'h40, 1'b0, 8'h80, 1'b1);
`endif

      // start during RUN cycle 3 must be ignored
      @(negedge clk);
      issue(8'h05, 8'h03, 1'b0);
      follow(4, dc, bc);
      chk("ign_res", result, 8'h08);
      chk("ign_ovf", overflow, 0);
      chk("ign_lat", dc, W + 1);
      chk("ign_busycnt", bc, W);

      // back-to-back: start raised in the DONE cycle
      chk("b2b_done_now", done, 1);
      issue(8'h10, 8'h20, 1'b1);
      follow(0, dc, bc);
      chk("b2b_res", result, 8'hF0);
      chk("b2b_ovf", overflow, 0);
      chk("b2b_lat", dc, W + 1);
      chk("b2b_busycnt", bc, W);

      // reset while cnt==4
      @(negedge clk);
      issue(8'h55, 8'h22, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_ovf", overflow, 0);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("mid_rst_no_done", dones, 0);

      op("post_rst_add", 8'h55, 8'h22, 1'b0, 8'h77, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
